seq_divider48_24: RTL and testbench
===================================

SEQ_DIVIDER48_24 -- requirements
Module: seq_divider48_24

Interface
REQ-001 SHALL have parameter N, default 24: divisor, quotient and remainder width; the dividend width is 2N.
REQ-002 SHALL have port clkn_i, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn_i, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid_i, input, 1: an operand pair is offered.
REQ-005 SHALL have port in_ready_o, output, 1: the block can accept operands.
REQ-006 SHALL have port dividend_i, input, 2N: unsigned dividend (same width as a multiplier product).
REQ-007 SHALL have port divisor_i, input, N: unsigned divisor.
REQ-008 SHALL have port out_valid_o, output, 1: the result is valid.
REQ-009 SHALL have port out_ready_i, input, 1: the consumer accepts the result.
REQ-010 SHALL have port quotient_o, output, N: the quotient.
REQ-011 SHALL have port remainder_o, output, N: the remainder.
REQ-012 SHALL have port dz_o, output, 1: divide-by-zero flag, qualified by out_valid_o.
REQ-013 SHALL have port ovf_o, output, 1: quotient-overflow flag, qualified by out_valid_o.

Function
REQ-014 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-015 SHALL assert in_ready_o only in IDLE; an operand pair is accepted when in_valid_i and in_ready_o are both 1, and is registered on that edge.
REQ-016 SHALL, on accept, check the special cases in this priority order:
  - divisor==0 -> dz;
  - else dividend[2N-1:N] >= divisor -> ovf;
  - else normal.
REQ-017 SHALL compute a normal division as unsigned radix-2 non-restoring division, one quotient bit per cycle in CALC for exactly N cycles, MSB first.
REQ-018 SHALL apply the final remainder correction (add divisor back if the partial remainder is negative) in the last CALC cycle, so that remainder_o < divisor and dividend == quotient*divisor + remainder.
REQ-019 SHALL hold the partial remainder in an N+1-bit signed register; no other internal width is wider than 2N.
REQ-020 SHALL give a normal-case latency from accept edge to out_valid_o high of N+1 cycles (N in CALC, then DONE).
REQ-021 SHALL produce these special-case results:
  - dz: quotient = all ones, remainder = dividend[N-1:0], dz_o = 1;
  - ovf: quotient = all ones, remainder = 0, ovf_o = 1.
REQ-022 SHALL hold out_valid_o and all results stable in DONE until out_ready_i=1, then return to IDLE on that edge.
REQ-023 SHALL NOT assert in_ready_o in the DONE-to-IDLE handoff cycle; back-to-back throughput is therefore one operation per N+2 cycles minimum.
REQ-024 SHALL ignore in_valid_i and operand changes while in CALC or DONE.

Reset
REQ-025 SHALL, on rstn_i low at any time including mid-CALC, abort the operation, enter IDLE and clear every output: in_ready_o=0 while in reset, out_valid_o=0, quotient_o=0, remainder_o=0, dz_o=0, ovf_o=0.
REQ-026 SHALL assert in_ready_o=1 on the first clkn_i edge after rstn_i is released.

Configuration
REQ-027 SHALL use macro DIV_FAST_SPECIAL_EN, which sets how the special cases are handled:
  - defined: dz and ovf skip CALC and go from accept directly to DONE, giving a latency of 1 cycle;
  - undefined: dz and ovf still spend N CALC cycles (iteration result discarded), giving a latency of N+1; the result values are identical in both builds.

Structure
REQ-028 SHALL take the FSM state encoding, the N default and the special-case priority constants from the shared package nla_div_pkg.
REQ-029 SHALL place one non-restoring iteration (shift, add/subtract divisor, quotient bit) in the sub-module div_nr_step, instantiated once.

Verification
REQ-030 SHALL cover: dividend=1000, divisor=7 -> quotient=142, remainder=6, flags 0, out_valid_o 25 cycles after accept.
REQ-031 SHALL cover: dividend=0xFFFFFE000001, divisor=0xFFFFFF -> quotient=0xFFFFFF, remainder=0.
REQ-032 SHALL cover: dividend=0x123, divisor=0 -> dz_o=1, quotient=0xFFFFFF, remainder=0x000123, with latency 1 (macro defined) or 25 (macro undefined).
REQ-033 SHALL cover: dividend=0x000001000000, divisor=1 -> ovf_o=1, quotient=0xFFFFFF, remainder=0.
REQ-034 SHALL cover: out_ready_i held 0 for 5 cycles in DONE -> results stable and in_ready_o=0; a second operand pair offered then is accepted only after return to IDLE.
REQ-035 SHALL cover: rstn_i pulsed low at CALC cycle 10 -> all outputs 0 immediately, and a new 1000/7 started after release gives 142 r 6.

Source files
------------

// File: rtl/nla_div_pkg.sv
// Shared definitions for the sequential 2N/N unsigned divider.
// Provides:
//   DIV_N_DEFAULT  - default operand width N (divisor/quotient/remainder)
//   div_state_e    - FSM state encoding (IDLE, CALC, DONE)
//   div_special_e  - special-case classes; special_kind() resolves their
//                    priority (divide-by-zero first, then quotient overflow)
package nla_div_pkg;

  localparam int unsigned DIV_N_DEFAULT = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_OVF  = 2'd1,
    SP_DZ   = 2'd2
  } div_special_e;

  // Divide-by-zero wins over overflow: with divisor 0 the overflow test
  // (high half >= divisor) is always true and must not mask dz.
  function automatic div_special_e special_kind(input logic is_dz,
                                                input logic is_ovf);
    if (is_dz) return SP_DZ;
    if (is_ovf) return SP_OVF;
    return SP_NONE;
  endfunction

endpackage

// File: rtl/div_nr_step.sv
// One radix-2 non-restoring division iteration (pure combinational).
// Ports:
//   rem_i     - current signed partial remainder (N+1 bits)
//   quo_i     - shift register: remaining dividend bits (MSB next) with
//               quotient bits accumulating from the LSB side
//   divisor_i - unsigned divisor
//   rem_o     - next partial remainder
//   quo_o     - quo_i shifted left by one with the new quotient bit at bit 0
module div_nr_step
  import nla_div_pkg::*;
#(
  parameter int unsigned N = DIV_N_DEFAULT
) (
  input  logic signed [N:0]   rem_i,
  input  logic        [N-1:0] quo_i,
  input  logic        [N-1:0] divisor_i,
  output logic signed [N:0]   rem_o,
  output logic        [N-1:0] quo_o
);

  // 2R+bit spans [-2D, 2D) so needs one bit more than the remainder;
  // after the add/subtract the result is back in [-D, D).
  logic signed [N+1:0] shifted;
  logic signed [N+1:0] dvs_ext;
  logic signed [N+1:0] sum;
  logic                qbit;

  always_comb begin
    shifted = {rem_i, quo_i[N-1]};
    dvs_ext = {2'b00, divisor_i};
    sum     = rem_i[N] ? (shifted + dvs_ext) : (shifted - dvs_ext);
    rem_o   = sum[N:0];
    // Top two bits of sum are equal by the range argument above.
    qbit    = ~sum[N+1];
    quo_o   = quo_i << 1;
    quo_o[0] = qbit;
  end

endmodule

// File: rtl/seq_divider48_24.sv
// Sequential unsigned divider: 2N-bit dividend / N-bit divisor, one
// quotient bit per cycle (radix-2 non-restoring), valid/ready handshakes.
// Ports:
//   clkn_i, rstn_i          - clock (rising edge), async active-low reset
//   in_valid_i/in_ready_o   - operand handshake; dividend_i, divisor_i
//   out_valid_o/out_ready_i - result handshake; quotient_o, remainder_o,
//                             dz_o (divide by zero), ovf_o (quotient overflow)
// Build option: define DIV_FAST_SPECIAL_EN to send dz/ovf operands straight
// to DONE (latency 1); otherwise they spend N CALC cycles like a normal op.
module seq_divider48_24
  import nla_div_pkg::*;
#(
  parameter int unsigned N = DIV_N_DEFAULT
) (
  input  logic           clkn_i,
  input  logic           rstn_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [2*N-1:0] dividend_i,
  input  logic [N-1:0]   divisor_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [N-1:0]   quotient_o,
  output logic [N-1:0]   remainder_o,
  output logic           dz_o,
  output logic           ovf_o
);

  localparam int unsigned CW = $clog2(N + 1);

  div_state_e         state_q, state_d;
  div_special_e       kind_q, kind_d;
  logic signed [N:0]  rem_q, rem_d;
  logic [N-1:0]       quo_q, quo_d;
  logic [N-1:0]       dvs_q, dvs_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               rdy_q;

  logic signed [N:0]  step_rem;
  logic [N-1:0]       step_quo;
  logic signed [N:0]  rem_fix;
  logic               accept;
  logic               last;
  div_special_e       acc_kind;

  div_nr_step #(.N(N)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // rdy_q keeps in_ready_o low while in reset and rises on the first edge
  // after release, even though the FSM already sits in IDLE.
  assign in_ready_o  = (state_q == ST_IDLE) && rdy_q;
  assign out_valid_o = (state_q == ST_DONE);
  assign quotient_o  = out_valid_o ? quo_q : '0;
  assign remainder_o = out_valid_o ? rem_q[N-1:0] : '0;
  assign dz_o        = out_valid_o && (kind_q == SP_DZ);
  assign ovf_o       = out_valid_o && (kind_q == SP_OVF);

  assign accept   = in_valid_i && in_ready_o;
  assign last     = (cnt_q == CW'(N - 1));
  assign acc_kind = special_kind(divisor_i == '0,
                                 dividend_i[2*N-1:N] >= divisor_i);
  assign rem_fix  = step_rem[N] ? (step_rem + $signed({1'b0, dvs_q}))
                                : step_rem;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          kind_d  = acc_kind;
          dvs_d   = divisor_i;
          rem_d   = {1'b0, dividend_i[2*N-1:N]};
          quo_d   = dividend_i[N-1:0];
          cnt_d   = '0;
          state_d = ST_CALC;
`ifdef DIV_FAST_SPECIAL_EN
          if (acc_kind != SP_NONE) begin
            quo_d   = '1;
            rem_d   = (acc_kind == SP_DZ) ? {1'b0, dividend_i[N-1:0]} : '0;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + CW'(1);
        // Special-case operands freeze the working registers so the
        // dividend low half is still in quo_q for the dz remainder.
        if (kind_q == SP_NONE) begin
          rem_d = last ? rem_fix : step_rem;
          quo_d = step_quo;
        end else if (last) begin
          quo_d = '1;
          rem_d = (kind_q == SP_DZ) ? {1'b0, quo_q} : '0;
        end
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkn_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      kind_q  <= SP_NONE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_divider48_24.sv
// Directed-vector bench for seq_divider48_24 (N = 24). Honours
// DIV_FAST_SPECIAL_EN for the expected special-case latency.
module tb_seq_divider48_24;

  localparam int unsigned N = 24;
  localparam int unsigned NORM_LAT = 25;
`ifdef DIV_FAST_SPECIAL_EN
  localparam int unsigned SP_LAT = 1;
`else
  localparam int unsigned SP_LAT = 25;
`endif

  logic           clkn_i = 1'b0;
  logic           rstn_i;
  logic           in_valid_i;
  logic           in_ready_o;
  logic [2*N-1:0] dividend_i;
  logic [N-1:0]   divisor_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [N-1:0]   quotient_o;
  logic [N-1:0]   remainder_o;
  logic           dz_o;
  logic           ovf_o;

  int n_checks = 0;
  int n_err    = 0;

  seq_divider48_24 #(.N(N)) dut (
    .clkn_i      (clkn_i),
    .rstn_i      (rstn_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .dz_o        (dz_o),
    .ovf_o       (ovf_o)
  );

  always #5 clkn_i = ~clkn_i;

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clkn_i);
    #1;
  endtask

  // Present operands and hold until the accept edge.
  task automatic offer(input string tag, input logic [2*N-1:0] dvd,
                       input logic [N-1:0] dvs);
    int unsigned n;
    n = 0;
    dividend_i = dvd;
    divisor_i  = dvs;
    in_valid_i = 1'b1;
    while (!in_ready_o && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_ready"}, 64'(in_ready_o), 64'd1);
    step();
    in_valid_i = 1'b0;
  endtask

  // Called just after the accept edge; returns the accept-to-valid latency.
  task automatic wait_valid(output int unsigned lat);
    lat = 1;
    while (!out_valid_o && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [N-1:0] eq,
                              input logic [N-1:0] er, input logic edz,
                              input logic eovf);
    chk({tag, "_valid"}, 64'(out_valid_o), 64'd1);
    chk({tag, "_q"}, 64'(quotient_o), 64'(eq));
    chk({tag, "_r"}, 64'(remainder_o), 64'(er));
    chk({tag, "_dz"}, 64'(dz_o), 64'(edz));
    chk({tag, "_ovf"}, 64'(ovf_o), 64'(eovf));
    chk({tag, "_busy"}, 64'(in_ready_o), 64'd0);
  endtask

  // Accept the result; in_ready_o must stay low in the handoff cycle.
  task automatic consume(input string tag);
    out_ready_i = 1'b1;
    chk({tag, "_handoff_rdy"}, 64'(in_ready_o), 64'd0);
    step();
    out_ready_i = 1'b0;
    chk({tag, "_idle_valid"}, 64'(out_valid_o), 64'd0);
    chk({tag, "_idle_rdy"}, 64'(in_ready_o), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [2*N-1:0] dvd,
                        input logic [N-1:0] dvs, input logic [N-1:0] eq,
                        input logic [N-1:0] er, input logic edz,
                        input logic eovf, input int unsigned elat);
    int unsigned lat;
    offer(tag, dvd, dvs);
    wait_valid(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    check_result(tag, eq, er, edz, eovf);
    consume(tag);
  endtask

  initial begin
    int unsigned lat;
    rstn_i      = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    dividend_i  = '0;
    divisor_i   = '0;
    #1;
    chk("rst_rdy", 64'(in_ready_o), 64'd0);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_q", 64'(quotient_o), 64'd0);
    chk("rst_r", 64'(remainder_o), 64'd0);
    chk("rst_flags", 64'({dz_o, ovf_o}), 64'd0);
    repeat (2) step();
    chk("rst_hold_rdy", 64'(in_ready_o), 64'd0);
    @(negedge clkn_i);
    rstn_i = 1'b1;
    #1;
    chk("rel_rdy_pre", 64'(in_ready_o), 64'd0);
    step();
    chk("rel_rdy_post", 64'(in_ready_o), 64'd1);

    // Normal divisions.
    run_op("d1000_7", 48'd1000, 24'd7, 24'd142, 24'd6, 1'b0, 1'b0, NORM_LAT);
    run_op("dmax", 48'hFFFFFE000001, 24'hFFFFFF, 24'hFFFFFF, 24'd0,
           1'b0, 1'b0, NORM_LAT);
    run_op("d2p25_3", 48'h000002000000, 24'd3, 24'hAAAAAA, 24'd2,
           1'b0, 1'b0, NORM_LAT);
    run_op("d0_7", 48'd0, 24'd7, 24'd0, 24'd0, 1'b0, 1'b0, NORM_LAT);

    // Special cases.
    run_op("dz123", 48'h123, 24'd0, 24'hFFFFFF, 24'h000123, 1'b1, 1'b0,
           SP_LAT);
    run_op("dzmax", 48'hFFFFFFFFFFFF, 24'd0, 24'hFFFFFF, 24'hFFFFFF,
           1'b1, 1'b0, SP_LAT);
    run_op("ovf1", 48'h000001000000, 24'd1, 24'hFFFFFF, 24'd0, 1'b0, 1'b1,
           SP_LAT);
    run_op("ovf_eq", 48'h000005000000, 24'd5, 24'hFFFFFF, 24'd0, 1'b0, 1'b1,
           SP_LAT);

    // Back-pressure in DONE with a second operand pair waiting.
    offer("bp1", 48'd1000, 24'd7);
    wait_valid(lat);
    chk("bp1_lat", 64'(lat), 64'(NORM_LAT));
    dividend_i = 48'd100;
    divisor_i  = 24'd10;
    in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", {31'd0, out_valid_o, in_ready_o, quotient_o, remainder_o[7:0]},
          {31'd0, 1'b1, 1'b0, 24'd142, 8'd6});
    end
    out_ready_i = 1'b1;
    chk("bp_handoff_rdy", 64'(in_ready_o), 64'd0);
    step();
    out_ready_i = 1'b0;
    chk("bp_idle_rdy", 64'(in_ready_o), 64'd1);
    step();
    in_valid_i = 1'b0;
    wait_valid(lat);
    chk("bp2_lat", 64'(lat), 64'(NORM_LAT));
    check_result("bp2", 24'd10, 24'd0, 1'b0, 1'b0);
    consume("bp2");

    // Reset in the middle of CALC.
    offer("mid", 48'd1000, 24'd7);
    repeat (9) step();
    rstn_i = 1'b0;
    #1;
    chk("mid_rst_rdy", 64'(in_ready_o), 64'd0);
    chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
    chk("mid_rst_q", 64'(quotient_o), 64'd0);
    chk("mid_rst_r", 64'(remainder_o), 64'd0);
    chk("mid_rst_flags", 64'({dz_o, ovf_o}), 64'd0);
    repeat (2) step();
    @(negedge clkn_i);
    rstn_i = 1'b1;
    step();
    chk("mid_rel_rdy", 64'(in_ready_o), 64'd1);
    run_op("after_rst", 48'd1000, 24'd7, 24'd142, 24'd6, 1'b0, 1'b0,
           NORM_LAT);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
